// File: rtl/core2_mul_dispatcher.sv
// core2_mul_dispatcher
//   Issues one 128x128 multiply at a time to the multiplier core on behalf of
//   the ECC sequencer and returns the 256-bit product (or an error) to it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (sequencer -> dispatcher)
//   req_op, req_a, req_b     operation code and operands
//   rsp_valid/rsp_ready      response handshake (dispatcher -> sequencer)
//   rsp_data, rsp_err        product (zero on error) and error flag
//   select_line              operation select towards the core
//   core_a, core_b           operands towards the core
//   In_Busy                  one-cycle start strobe towards the core
//   Out_Busy                 core busy indication
//   C_Out                    core product, valid when Out_Busy falls
module core2_mul_dispatcher #(
  parameter logic [2:0] MUL      = 3'b001,
  parameter logic [2:0] IDLE_SEL = 3'b000,
  parameter int         ACK_WAIT = 8,
  parameter int         TIMEOUT  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] rsp_data,
  output logic         rsp_err,
  output logic [2:0]   select_line,
  output logic [127:0] core_a,
  output logic [127:0] core_b,
  output logic         In_Busy,
  input  logic         Out_Busy,
  input  logic [255:0] C_Out
);

  localparam int CNT_MAX = (TIMEOUT > ACK_WAIT) ? TIMEOUT : ACK_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next, count_inc;
  logic               err_next;
  logic               capture;
  logic               in_flight_next;
  logic               enter_resp;
  logic               req_fire;
  logic               rsp_fire;

  logic               req_ready_reg;
  logic               rsp_valid_reg;
  logic [255:0]       rsp_data_reg;
  logic               rsp_err_reg;
  logic [2:0]         select_line_reg;
  logic [127:0]       core_a_reg;
  logic [127:0]       core_b_reg;
  logic               in_busy_reg;

  assign req_ready   = req_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;
  assign select_line = select_line_reg;
  assign core_a      = core_a_reg;
  assign core_b      = core_b_reg;
  assign In_Busy     = in_busy_reg;

  assign req_fire = req_valid & req_ready_reg;
  assign rsp_fire = rsp_valid_reg & rsp_ready;

  // Saturating increment: the counter never wraps back to zero.
  assign count_inc = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Out_Busy is deliberately not looked at here: a stale busy core
        // must not influence an idle dispatcher.
        count_next = '0;
        if (req_fire) begin
          if (req_op == MUL) begin
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_RESP;
            err_next   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        count_next = '0;
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (Out_Busy) begin
          state_next = ST_WAIT_DONE;
          count_next = '0;
        end else if (count_reg >= CNT_W'(ACK_WAIT - 1)) begin
          state_next = ST_RESP;
          err_next   = 1'b1;
        end else begin
          count_next = count_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!Out_Busy) begin
          state_next = ST_RESP;
          capture    = 1'b1;
        end else if (count_reg >= CNT_W'(TIMEOUT - 1)) begin
          state_next = ST_RESP;
          err_next   = 1'b1;
        end else begin
          count_next = count_inc;
        end
      end
      ST_RESP: begin
        count_next = '0;
        if (rsp_fire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // The core drives its operand path only while selected, so select and
  // operands stay put from ISSUE until the product has been captured.
  assign in_flight_next = (state_next == ST_ISSUE) ||
                          (state_next == ST_WAIT_ACK) ||
                          (state_next == ST_WAIT_DONE);
  assign enter_resp     = (state_next == ST_RESP) && (state_reg != ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      count_reg       <= '0;
      req_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_err_reg     <= 1'b0;
      select_line_reg <= IDLE_SEL;
      core_a_reg      <= '0;
      core_b_reg      <= '0;
      in_busy_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      // All handshake and core-facing outputs are registered and derived
      // from the next state so they line up with the state they belong to.
      req_ready_reg   <= (state_next == ST_IDLE);
      rsp_valid_reg   <= (state_next == ST_RESP);
      in_busy_reg     <= (state_next == ST_ISSUE);
      select_line_reg <= in_flight_next ? MUL : IDLE_SEL;

      if ((state_reg == ST_IDLE) && (state_next == ST_ISSUE)) begin
        core_a_reg <= req_a;
        core_b_reg <= req_b;
      end else if (!in_flight_next) begin
        core_a_reg <= '0;
        core_b_reg <= '0;
      end

      // Response payload is written once on entry to RESP and then held
      // until the sequencer takes it.
      if (enter_resp) begin
        rsp_err_reg  <= err_next;
        rsp_data_reg <= capture ? C_Out : '0;
      end
    end
  end

endmodule

// File: tb/tb_core2_mul_dispatcher.sv
// tb_core2_mul_dispatcher
//   Directed bench for core2_mul_dispatcher with a small behavioural model
//   of the multiplier core (normal, never-acknowledging and stuck-busy modes).
module tb_core2_mul_dispatcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_data;
  logic         rsp_err;
  logic [2:0]   select_line;
  logic [127:0] core_a;
  logic [127:0] core_b;
  logic         In_Busy;
  logic         Out_Busy = 1'b0;
  logic [255:0] C_Out = '0;

  localparam logic [2:0] MUL      = 3'b001;
  localparam logic [2:0] IDLE_SEL = 3'b000;

  int checks = 0;
  int errors = 0;

  // Core model controls
  int   core_mode   = 0;   // 0 normal, 1 never acknowledges, 2 stuck busy
  int   busy_cycles = 4;
  int   busy_left   = 0;
  logic model_clear = 1'b0;
  int   in_busy_seen = 0;

  core2_mul_dispatcher dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .select_line (select_line),
    .core_a      (core_a),
    .core_b      (core_b),
    .In_Busy     (In_Busy),
    .Out_Busy    (Out_Busy),
    .C_Out       (C_Out)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mul256(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] xa;
    logic [255:0] xb;
    xa = {128'b0, a};
    xb = {128'b0, b};
    return xa * xb;
  endfunction

  always @(posedge clk) begin
    if (model_clear) begin
      Out_Busy  <= 1'b0;
      busy_left <= 0;
    end else if (In_Busy) begin
      C_Out <= mul256(core_a, core_b);
      if (core_mode == 0) begin
        Out_Busy  <= 1'b1;
        busy_left <= busy_cycles;
      end else if (core_mode == 2) begin
        Out_Busy  <= 1'b1;
        busy_left <= 0;
      end
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else if (busy_left == 1) begin
      busy_left <= 0;
      Out_Busy  <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (In_Busy) in_busy_seen = in_busy_seen + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns one step after the accepting edge.
  task automatic send_req(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    while (!req_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!req_ready) check("req_accept_timeout", 256'(0), 256'(1));
    tick();
    req_valid = 1'b0;
  endtask

  // Counts clock edges until rsp_valid is seen; 0 means present already.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 3000) begin
      tick();
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 256'(0), 256'(1));
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int seen_before;
    logic [255:0] all_ones_sq;
    all_ones_sq = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1};

    // ---- 1: reset with a pending request
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = MUL;
    req_a     = 128'd3;
    req_b     = 128'd5;
    tick(); tick(); tick();
    check("rst_req_ready",   256'(req_ready), 256'(0));
    check("rst_rsp_valid",   256'(rsp_valid), 256'(0));
    check("rst_rsp_err",     256'(rsp_err), 256'(0));
    check("rst_rsp_data",    rsp_data, 256'(0));
    check("rst_select",      256'(select_line), 256'(IDLE_SEL));
    check("rst_core_a",      256'(core_a), 256'(0));
    check("rst_core_b",      256'(core_b), 256'(0));
    check("rst_in_busy",     256'(In_Busy), 256'(0));
    rst = 1'b0;
    tick();
    check("rel_req_ready",   256'(req_ready), 256'(1));
    check("rel_no_accept",   256'(In_Busy), 256'(0));

    // ---- 2: basic multiplies (core busy 4 cycles)
    send_req(MUL, 128'd3, 128'd5);
    check("mul_in_busy_hi",  256'(In_Busy), 256'(1));
    check("mul_select",      256'(select_line), 256'(MUL));
    check("mul_core_a",      256'(core_a), 256'(3));
    check("mul_core_b",      256'(core_b), 256'(5));
    check("mul_req_ready",   256'(req_ready), 256'(0));
    tick();
    check("mul_in_busy_lo",  256'(In_Busy), 256'(0));
    wait_rsp(lat);
    check("mul_latency",     256'(lat + 1), 256'(6));
    check("mul_3x5",         rsp_data, 256'd15);
    check("mul_3x5_err",     256'(rsp_err), 256'(0));
    check("mul_rsp_select",  256'(select_line), 256'(IDLE_SEL));
    take_rsp();
    check("mul_rsp_gone",    256'(rsp_valid), 256'(0));

    send_req(MUL, {128{1'b1}}, {128{1'b1}});
    wait_rsp(lat);
    check("mul_max",         rsp_data, all_ones_sq);
    check("mul_max_err",     256'(rsp_err), 256'(0));
    take_rsp();

    // ---- 3: backpressure
    send_req(MUL, 128'd11, 128'd13);
    wait_rsp(lat);
    req_valid = 1'b1;
    req_op    = MUL;
    req_a     = 128'd2;
    req_b     = 128'd21;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid",  256'(rsp_valid), 256'(1));
      check("bp_rsp_data",   rsp_data, 256'd143);
      check("bp_req_ready",  256'(req_ready), 256'(0));
      tick();
    end
    take_rsp();
    check("bp_rsp_done",     256'(rsp_valid), 256'(0));
    send_req(MUL, 128'd2, 128'd21);
    wait_rsp(lat);
    check("bp_second",       rsp_data, 256'd42);
    take_rsp();

    // ---- 4: unsupported op
    seen_before = in_busy_seen;
    send_req(3'b010, 128'd6, 128'd7);
    check("bad_rsp_valid",   256'(rsp_valid), 256'(1));
    check("bad_rsp_err",     256'(rsp_err), 256'(1));
    check("bad_rsp_data",    rsp_data, 256'(0));
    check("bad_select",      256'(select_line), 256'(IDLE_SEL));
    take_rsp();
    check("bad_no_in_busy",  256'(in_busy_seen - seen_before), 256'(0));

    // ---- 5a: core never acknowledges
    core_mode = 1;
    send_req(MUL, 128'd4, 128'd4);
    wait_rsp(lat);
    check("ack_to_latency",  256'(lat), 256'(9));
    check("ack_to_err",      256'(rsp_err), 256'(1));
    check("ack_to_data",     rsp_data, 256'(0));
    take_rsp();

    // ---- 5b: core stuck busy
    core_mode = 2;
    send_req(MUL, 128'd4, 128'd4);
    wait_rsp(lat);
    check("busy_to_latency", 256'(lat), 256'(1026));
    check("busy_to_err",     256'(rsp_err), 256'(1));
    check("busy_to_data",    rsp_data, 256'(0));
    check("busy_to_select",  256'(select_line), 256'(IDLE_SEL));
    take_rsp();
    model_clear = 1'b1;
    tick();
    model_clear = 1'b0;
    core_mode   = 0;

    // ---- 6: reset during WAIT_DONE, then a fresh request
    busy_cycles = 20;
    send_req(MUL, 128'd100, 128'd100);
    tick(); tick(); tick(); tick();
    check("mid_select",      256'(select_line), 256'(MUL));
    rst = 1'b1;
    tick(); tick();
    check("mid_rst_valid",   256'(rsp_valid), 256'(0));
    check("mid_rst_select",  256'(select_line), 256'(IDLE_SEL));
    check("mid_rst_core_a",  256'(core_a), 256'(0));
    check("mid_rst_ready",   256'(req_ready), 256'(0));
    rst = 1'b0;
    n = 0;
    while (Out_Busy && n < 100) begin
      tick();
      n++;
    end
    if (Out_Busy) check("core_drain_timeout", 256'(0), 256'(1));
    tick(); tick();
    check("mid_no_stale",    256'(rsp_valid), 256'(0));
    busy_cycles = 4;
    send_req(MUL, 128'd7, 128'd9);
    wait_rsp(lat);
    check("post_rst_7x9",    rsp_data, 256'd63);
    check("post_rst_err",    256'(rsp_err), 256'(0));
    take_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
